// File: rtl/rf_dbg_pkg.sv
// Shared definitions for the register-file debug reader and register_file users.
package rf_dbg_pkg;

  localparam int ADDRESS_WIDTH = 5;
  localparam int DATA_WIDTH    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Output beat stream of the register-file dump reader.
//
// Handshake: a beat transfers on a rising clk edge where out_valid and
// out_ready are both high. Once out_valid rises, the master holds out_valid,
// out_data, out_addr and out_last unchanged until that transfer happens.
// out_ready may be driven freely by the consumer.
interface regfile_dump_reader_if #(
  parameter int AW = rf_dbg_pkg::ADDRESS_WIDTH,
  parameter int DW = rf_dbg_pkg::DATA_WIDTH
) ();

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;

  modport master (
    output out_valid,
    input  out_ready,
    output out_data,
    output out_addr,
    output out_last
  );

  modport slave (
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_addr,
    input  out_last
  );

endinterface

// File: rtl/regfile_dump_reader.sv
// Walks a register range through a spare asynchronous read port of the
// register file and streams one beat per register. Each value is snapshotted
// in FETCH, so later writes to that register do not alter the pending beat.
module regfile_dump_reader
  import rf_dbg_pkg::*;
#(
  parameter int AW = ADDRESS_WIDTH,
  parameter int DW = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW-1:0]         first_addr,
  input  logic [AW-1:0]         last_addr,
  output logic [AW-1:0]         rf_addr,
  input  logic [DW-1:0]         rf_data,
  output logic                  busy,
  output logic                  done,
  output dump_state_t           dbg_state,
  regfile_dump_reader_if.master out_if
);

  dump_state_t   r_state;
  dump_state_t   w_next;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] r_last_q;
  logic [DW-1:0] r_out_data;
  logic [AW-1:0] r_out_addr;
  logic          r_out_last;
  logic          r_out_valid;
  logic          r_busy;
  logic          r_done;
  logic          w_hs;

  assign w_hs = r_out_valid & out_if.out_ready;

  // Next-state decode; start only matters in IDLE, and an empty range skips straight to DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (first_addr <= last_addr) ? FETCH : DONE;
      FETCH:   w_next = SEND;
      SEND:    if (w_hs) w_next = r_out_last ? DONE : FETCH;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State, range pointer and registered outputs; status flags follow the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_last_q    <= '0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_out_valid <= (w_next == SEND);
      r_busy      <= (w_next != IDLE);
      r_done      <= (w_next == DONE);
      case (r_state)
        IDLE: begin
          if (start && (first_addr <= last_addr)) begin
            r_ptr    <= first_addr;
            r_last_q <= last_addr;
          end
        end
        FETCH: begin
          r_out_data <= rf_data;
          r_out_addr <= r_ptr;
          r_out_last <= (r_ptr == r_last_q);
        end
        SEND: begin
          // Pointer stops at last_q, so a range ending at the top never wraps.
          if (w_hs && !r_out_last) r_ptr <= r_ptr + AW'(1);
        end
        default: ;
      endcase
    end
  end

  // The read port sees the pointer only while fetching; it idles at register 0.
  assign rf_addr = (r_state == FETCH) ? r_ptr : '0;

  assign busy             = r_busy;
  assign done             = r_done;
  assign dbg_state        = r_state;
  assign out_if.out_valid = r_out_valid;
  assign out_if.out_data  = r_out_data;
  assign out_if.out_addr  = r_out_addr;
  assign out_if.out_last  = r_out_last;

endmodule
